// File: rtl/vc_read_arbiter.sv
// Packet-aware round-robin reader for VC_NUM virtual-channel buffers.
// It holds one VC until the packet's TAIL has gone out, and it only reads when a downstream credit is available.
module vc_read_arbiter #(
  parameter int unsigned VC_NUM    = 4,
  parameter int unsigned FLIT_SIZE = 8,
  parameter int unsigned CREDITS   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [VC_NUM*FLIT_SIZE-1:0]  data_i,
  input  logic [VC_NUM-1:0]            empty_i,
  input  logic                         credit_i,
  output logic [VC_NUM-1:0]            read_o,
  output logic [FLIT_SIZE-1:0]         flit_o,
  output logic                         valid_o,
  output logic [$clog2(VC_NUM)-1:0]    grant_o,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt_o,
  output logic                         error_o
);

  localparam int unsigned VcW  = $clog2(VC_NUM);
  localparam int unsigned CntW = $clog2(CREDITS + 1);

  localparam logic [1:0] TypeHead = 2'b10;
  localparam logic [1:0] TypeBody = 2'b00;
  localparam logic [1:0] TypeTail = 2'b01;

  localparam logic [CntW-1:0] CntMax = CntW'(CREDITS);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e               r_state, w_state_next;
  logic [VcW-1:0]       r_rr_ptr, w_rr_ptr_next;
  logic [VcW-1:0]       r_lock_vc, w_lock_vc_next;
  logic [CntW-1:0]      r_credit_cnt, w_credit_cnt_next;
  logic                 r_error, w_error_next;
  logic                 r_valid;
  logic [FLIT_SIZE-1:0] r_flit, w_flit_next;
  logic [VcW-1:0]       r_grant;

  logic [VC_NUM-1:0]    w_eligible;
  logic                 w_idle_found;
  logic [VcW-1:0]       w_idle_sel;
  logic                 w_req;
  logic [VcW-1:0]       w_sel;
  logic                 w_has_credit;
  logic                 w_read;
  logic [FLIT_SIZE-1:0] w_sel_flit;
  logic [1:0]           w_sel_type;

  // Only a packet start (HEAD or HEADTAIL, i.e. type MSB set) may win arbitration.
  always_comb begin
    for (int k = 0; k < VC_NUM; k++) begin
      w_eligible[k] = ~empty_i[k] & data_i[k*FLIT_SIZE + FLIT_SIZE - 1];
    end
  end

  // Scanning downward lets the candidate closest to r_rr_ptr be written last and win.
  always_comb begin
    logic [VcW-1:0] w_idx;
    w_idle_found = 1'b0;
    w_idle_sel   = r_rr_ptr;
    w_idx        = '0;
    for (int i = VC_NUM - 1; i >= 0; i--) begin
      w_idx = r_rr_ptr + VcW'(i);
      if (w_eligible[w_idx]) begin
        w_idle_found = 1'b1;
        w_idle_sel   = w_idx;
      end
    end
  end

  always_comb begin
    if (r_state == StLocked) begin
      w_sel = r_lock_vc;
      w_req = ~empty_i[r_lock_vc];
    end else begin
      w_sel = w_idle_sel;
      w_req = w_idle_found;
    end
  end

  assign w_has_credit = (r_credit_cnt != '0);
  assign w_read       = rst & w_req & w_has_credit;
  assign w_sel_flit   = data_i[32'(w_sel) * FLIT_SIZE +: FLIT_SIZE];
  assign w_sel_type   = w_sel_flit[FLIT_SIZE-1 -: 2];

  always_comb begin
    read_o = '0;
    if (w_read) begin
      read_o[w_sel] = 1'b1;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_rr_ptr_next  = r_rr_ptr;
    w_lock_vc_next = r_lock_vc;
    w_flit_next    = w_sel_flit;
    if (w_read) begin
      unique case (r_state)
        StIdle: begin
          if (w_sel_type == TypeHead) begin
            w_state_next   = StLocked;
            w_lock_vc_next = w_sel;
          end else begin
            w_rr_ptr_next = w_sel + VcW'(1);
          end
        end
        StLocked: begin
          // A stray packet start inside a packet is passed through as BODY.
          if (w_sel_type[1]) begin
            w_flit_next[FLIT_SIZE-1 -: 2] = TypeBody;
          end
          if (w_sel_type == TypeTail) begin
            w_state_next  = StIdle;
            w_rr_ptr_next = r_lock_vc + VcW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_credit_cnt_next = r_credit_cnt;
    w_error_next      = r_error;
    if (w_read && !credit_i) begin
      w_credit_cnt_next = r_credit_cnt - CntW'(1);
    end else if (!w_read && credit_i) begin
      if (r_credit_cnt == CntMax) begin
        w_error_next = 1'b1;
      end else begin
        w_credit_cnt_next = r_credit_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_rr_ptr     <= '0;
      r_lock_vc    <= '0;
      r_credit_cnt <= CntMax;
      r_error      <= 1'b0;
      r_valid      <= 1'b0;
      r_flit       <= '0;
      r_grant      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_rr_ptr     <= w_rr_ptr_next;
      r_lock_vc    <= w_lock_vc_next;
      r_credit_cnt <= w_credit_cnt_next;
      r_error      <= w_error_next;
      r_valid      <= w_read;
      if (w_read) begin
        r_flit  <= w_flit_next;
        r_grant <= w_sel;
      end
    end
  end

  assign flit_o       = r_flit;
  assign valid_o      = r_valid;
  assign grant_o      = r_grant;
  assign credit_cnt_o = r_credit_cnt;
  assign error_o      = r_error;

endmodule

// File: tb/tb_vc_read_arbiter.sv
// Bench for vc_read_arbiter: queue-backed VC buffers, a behavioural model, a negedge comparator,
// directed scenarios with literal expectations, then randomized packet traffic.
module tb_vc_read_arbiter;

  localparam int VC = 4;
  localparam int F  = 8;
  localparam int CR = 8;
  localparam int GW = $clog2(VC);
  localparam int CW = $clog2(CR + 1);

  logic            clk;
  logic            rst;
  logic            credit_i;
  logic [VC*F-1:0] data_i;
  logic [VC-1:0]   empty_i;
  logic [VC-1:0]   read_o;
  logic [F-1:0]    flit_o;
  logic            valid_o;
  logic [GW-1:0]   grant_o;
  logic [CW-1:0]   credit_cnt_o;
  logic            error_o;

  vc_read_arbiter #(
    .VC_NUM   (VC),
    .FLIT_SIZE(F),
    .CREDITS  (CR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .empty_i     (empty_i),
    .credit_i    (credit_i),
    .read_o      (read_o),
    .flit_o      (flit_o),
    .valid_o     (valid_o),
    .grant_o     (grant_o),
    .credit_cnt_o(credit_cnt_o),
    .error_o     (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VC buffers; only the driver process touches them.
  logic [F-1:0] q [VC][$];

  // Behavioural model state.
  bit           m_locked  = 1'b0;
  int           m_lock_vc = 0;
  int           m_rr      = 0;
  int           m_cnt     = CR;
  bit           m_err     = 1'b0;
  bit           m_valid   = 1'b0;
  logic [F-1:0] m_flit    = '0;
  int           m_grant   = 0;
  int           m_pop_vc  = -1;
  bit           m_clear   = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  bit [5:0]    lit_on   = '0;
  int unsigned lit_exp [6];
  int          lit_seq  = 0;
  int          lit_seen = 0;

  function automatic logic [1:0] front_type(int k);
    return data_i[k*F + F - 1 -: 2];
  endfunction

  // VC to be read this cycle under the arbitration rules, or -1.
  function automatic int pick();
    if (!rst || m_cnt == 0) return -1;
    if (m_locked) return empty_i[m_lock_vc] ? -1 : m_lock_vc;
    for (int i = 0; i < VC; i++) begin
      int k;
      k = (m_rr + i) % VC;
      if (!empty_i[k] && (front_type(k) == 2'b10 || front_type(k) == 2'b11)) return k;
    end
    return -1;
  endfunction

  function automatic logic [VC-1:0] exp_read();
    logic [VC-1:0] e;
    int k;
    e = '0;
    k = pick();
    if (k >= 0) e[k] = 1'b1;
    return e;
  endfunction

  initial begin
    forever begin
      int k;
      logic [F-1:0] f;
      @(posedge clk);
      m_pop_vc = -1;
      m_clear  = 1'b0;
      if (!rst) begin
        m_locked = 1'b0; m_lock_vc = 0; m_rr = 0; m_cnt = CR; m_err = 1'b0;
        m_valid = 1'b0; m_flit = '0; m_grant = 0; m_clear = 1'b1;
      end else begin
        k = pick();
        if (k >= 0 && !credit_i) m_cnt = m_cnt - 1;
        else if (k < 0 && credit_i) begin
          if (m_cnt == CR) m_err = 1'b1;
          else m_cnt = m_cnt + 1;
        end
        m_valid = (k >= 0);
        if (k >= 0) begin
          f        = data_i[k*F +: F];
          m_grant  = k;
          m_pop_vc = k;
          m_flit   = f;
          if (m_locked) begin
            if (f[F-1]) m_flit[F-1 -: 2] = 2'b00;
            if (f[F-1 -: 2] == 2'b01) begin
              m_locked = 1'b0;
              m_rr     = (k + 1) % VC;
            end
          end else if (f[F-1 -: 2] == 2'b10) begin
            m_locked  = 1'b1;
            m_lock_vc = k;
          end else begin
            m_rr = (k + 1) % VC;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic string sig_name(int s);
    case (s)
      0: return "read_o";
      1: return "valid_o";
      2: return "flit_o";
      3: return "grant_o";
      4: return "credit_cnt_o";
      default: return "error_o";
    endcase
  endfunction

  function automatic logic [31:0] sig_act(int s);
    case (s)
      0: return 32'(read_o);
      1: return 32'(valid_o);
      2: return 32'(flit_o);
      3: return 32'(grant_o);
      4: return 32'(credit_cnt_o);
      default: return 32'(error_o);
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("read_o", 32'(read_o), 32'(exp_read()));
        check("valid_o", 32'(valid_o), 32'(m_valid));
        check("flit_o", 32'(flit_o), 32'(m_flit));
        check("grant_o", 32'(grant_o), 32'(m_grant));
        check("credit_cnt_o", 32'(credit_cnt_o), 32'(m_cnt));
        check("error_o", 32'(error_o), 32'(m_err));
        if (lit_seq != lit_seen) begin
          lit_seen = lit_seq;
          for (int s = 0; s < 6; s++) begin
            if (lit_on[s]) check({"lit_", sig_name(s)}, sig_act(s), 32'(lit_exp[s]));
          end
        end
      end
    end
  end

  task automatic expect_lit(input int s, input int unsigned v);
    lit_on[s]  = 1'b1;
    lit_exp[s] = v;
    lit_seq++;
  endtask

  task automatic drive();
    for (int k = 0; k < VC; k++) begin
      empty_i[k]      = (q[k].size() == 0);
      data_i[k*F +: F] = (q[k].size() == 0) ? '0 : q[k][0];
    end
  endtask

  task automatic tick(input logic c, input logic r);
    @(posedge clk);
    #1;
    lit_on = '0;
    if (m_clear) begin
      for (int k = 0; k < VC; k++) q[k].delete();
    end else if (m_pop_vc >= 0) begin
      void'(q[m_pop_vc].pop_front());
    end
    credit_i = c;
    rst      = r;
    drive();
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
  endtask

  function automatic logic [F-3:0] pay();
    return (F-2)'($urandom);
  endfunction

  task automatic push_pkt(input int k);
    int len;
    logic [1:0] bt;
    len = int'($urandom_range(0, 4));
    if (len == 0) begin
      q[k].push_back({2'b11, pay()});
    end else begin
      q[k].push_back({2'b10, pay()});
      for (int i = 1; i < len; i++) begin
        bt = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
        q[k].push_back({bt, pay()});
      end
      q[k].push_back({2'b01, pay()});
    end
  endtask

  initial begin
    rst      = 1'b0;
    credit_i = 1'b0;
    drive();
    tick(1'b0, 1'b1);
    chk_en = 1'b1;
    expect_lit(0, 0); expect_lit(1, 0); expect_lit(2, 0);
    expect_lit(3, 0); expect_lit(4, 8); expect_lit(5, 0);
    tick(1'b0, 1'b1);

    // Two HEADTAIL flits on VC0 and VC2.
    q[0].push_back(8'hC1); q[2].push_back(8'hC2); drive();
    expect_lit(0, 4'b0001);
    tick(1'b0, 1'b1);
    expect_lit(0, 4'b0100); expect_lit(1, 1); expect_lit(3, 0); expect_lit(2, 8'hC1);
    tick(1'b0, 1'b1);
    expect_lit(0, 0); expect_lit(1, 1); expect_lit(3, 2); expect_lit(2, 8'hC2); expect_lit(4, 6);
    tick(1'b0, 1'b1);
    expect_lit(1, 0); expect_lit(3, 2);

    // Packet on VC1, HEADTAIL shows up on VC0 mid-packet.
    do_reset();
    q[1].push_back(8'h81); q[1].push_back(8'h02); q[1].push_back(8'h43); drive();
    expect_lit(0, 4'b0010);
    tick(1'b0, 1'b1);
    q[0].push_back(8'hC4); drive();
    expect_lit(0, 4'b0010); expect_lit(2, 8'h81); expect_lit(3, 1);
    tick(1'b0, 1'b1);
    expect_lit(0, 4'b0010); expect_lit(2, 8'h02);
    tick(1'b0, 1'b1);
    expect_lit(0, 4'b0001); expect_lit(2, 8'h43);
    tick(1'b0, 1'b1);
    expect_lit(0, 0); expect_lit(2, 8'hC4); expect_lit(3, 0);

    // Credit exhaustion, then a single credit pulse.
    do_reset();
    for (int i = 0; i < 10; i++) q[0].push_back(8'hC0 + 8'(i));
    drive();
    for (int i = 0; i < 8; i++) begin
      expect_lit(0, 4'b0001); expect_lit(4, 8 - i);
      tick(1'b0, 1'b1);
    end
    expect_lit(0, 0); expect_lit(4, 0); expect_lit(1, 1); expect_lit(2, 8'hC7);
    tick(1'b1, 1'b1);
    expect_lit(0, 0); expect_lit(1, 0);
    tick(1'b0, 1'b1);
    expect_lit(0, 4'b0001); expect_lit(4, 1);
    tick(1'b0, 1'b1);
    expect_lit(0, 0); expect_lit(1, 1); expect_lit(2, 8'hC8); expect_lit(4, 0);

    // Read and credit together at count 3, then overflow.
    do_reset();
    for (int i = 0; i < 6; i++) q[0].push_back(8'hD0 + 8'(i));
    drive();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
    credit_i = 1'b1;
    expect_lit(4, 3); expect_lit(0, 4'b0001);
    tick(1'b0, 1'b1);
    expect_lit(4, 3); expect_lit(0, 0); expect_lit(5, 0);
    do_reset();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    expect_lit(4, 8); expect_lit(5, 1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    expect_lit(5, 1);

    // Locked VC3 runs dry after BODY; lock must hold until TAIL.
    do_reset();
    q[3].push_back(8'h85); q[3].push_back(8'h06); drive();
    expect_lit(0, 4'b1000);
    tick(1'b0, 1'b1);
    expect_lit(0, 4'b1000);
    tick(1'b0, 1'b1);
    q[0].push_back(8'hC7); drive();
    expect_lit(0, 0); expect_lit(3, 3); expect_lit(2, 8'h06);
    tick(1'b0, 1'b1);
    expect_lit(0, 0); expect_lit(1, 0);
    q[3].push_back(8'h48); drive();
    expect_lit(0, 4'b1000);
    tick(1'b0, 1'b1);
    expect_lit(0, 4'b0001); expect_lit(2, 8'h48); expect_lit(3, 3);
    tick(1'b0, 1'b1);
    expect_lit(2, 8'hC7); expect_lit(3, 0);

    // BODY and TAIL fronts are ineligible while idle.
    do_reset();
    q[0].push_back(8'h09); q[1].push_back(8'h4A); q[2].push_back(8'hCB); drive();
    expect_lit(0, 4'b0100);
    tick(1'b0, 1'b1);
    expect_lit(0, 0); expect_lit(2, 8'hCB); expect_lit(3, 2);

    // Reset while locked on VC1.
    do_reset();
    q[1].push_back(8'h81); q[1].push_back(8'h02); q[1].push_back(8'h02); q[1].push_back(8'h43);
    drive();
    expect_lit(0, 4'b0010);
    tick(1'b0, 1'b1);
    rst = 1'b0;
    expect_lit(0, 0);
    tick(1'b0, 1'b1);
    expect_lit(0, 0); expect_lit(1, 0); expect_lit(2, 0);
    expect_lit(3, 0); expect_lit(4, 8); expect_lit(5, 0);
    tick(1'b0, 1'b1);
    q[1].push_back(8'hC1); q[0].push_back(8'hC0); drive();
    expect_lit(0, 4'b0001);

    // Randomized traffic, credits and occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 499) != 0));
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = int'($urandom_range(0, VC - 1));
        if (q[k].size() < 8) push_pkt(k);
      end
      drive();
    end

    tick(1'b0, 1'b1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vc_read_arbiter.md
VC_READ_ARBITER -- requirements
Module: vc_read_arbiter

Interface
REQ-001 SHALL have parameter VC_NUM, default 4: number of virtual-channel buffers served; power of two, 2..8.
REQ-002 SHALL have parameter FLIT_SIZE, default 8: flit width; bits [FLIT_SIZE-1:FLIT_SIZE-2] are the flit type (10 HEAD, 00 BODY, 01 TAIL, 11 HEADTAIL).
REQ-003 SHALL have parameter CREDITS, default 8: downstream buffer depth, i.e. the initial and maximum credit count.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 SHALL have port data_i  input  VC_NUM*FLIT_SIZE  front flit of each VC buffer; VC k occupies bits [k*FLIT_SIZE +: FLIT_SIZE].
REQ-007 SHALL have port empty_i  input  VC_NUM  per-VC buffer empty flag.
REQ-008 SHALL have port credit_i  input  1  one-cycle pulse; downstream has freed one slot.
REQ-009 SHALL have port read_o  output  VC_NUM  combinational, at most one bit set; pops the selected VC buffer this cycle.
REQ-010 SHALL have port flit_o  output  FLIT_SIZE  registered copy of the flit popped in the previous cycle.
REQ-011 SHALL have port valid_o  output  1  registered; flit_o is valid.
REQ-012 SHALL have port grant_o  output  clog2(VC_NUM)  registered index of the VC last read.
REQ-013 SHALL have port credit_cnt_o  output  clog2(CREDITS+1)  current credit count.
REQ-014 SHALL have port error_o  output  1  sticky; set on credit overflow.

Function
REQ-015 SHALL implement an FSM with states IDLE (no packet in progress) and LOCKED (packet in progress on VC lock_vc).
REQ-016 In IDLE, VC k SHALL be eligible iff empty_i[k]=0 and its front flit type is HEAD or HEADTAIL; BODY/TAIL fronts are ineligible.
REQ-017 In IDLE, the grant SHALL go to the first eligible VC searching from rr_ptr upward, wrapping modulo VC_NUM.
REQ-018 read_o[k] SHALL be asserted in the same cycle as the grant, and only if credit_cnt_o > 0; otherwise read_o=0.
REQ-019 On an IDLE read of a HEAD flit: next state LOCKED, lock_vc=k.
REQ-020 On an IDLE read of a HEADTAIL flit: stay IDLE, rr_ptr=(k+1) mod VC_NUM.
REQ-021 In LOCKED, read_o[lock_vc] SHALL equal ~empty_i[lock_vc] & (credit_cnt_o>0); all other read_o bits 0, whatever the other VCs hold.
REQ-022 In LOCKED, a read of a TAIL flit SHALL return the FSM to IDLE with rr_ptr=(lock_vc+1) mod VC_NUM; HEAD or HEADTAIL flits are forwarded as BODY, no state change.
REQ-023 An empty locked VC SHALL stall (no read), holding the lock indefinitely.
REQ-024 Cycle after any read: valid_o=1, flit_o=popped flit, grant_o=k; cycle with no read: valid_o=0, flit_o and grant_o hold. Latency is 1 cycle.
REQ-025 Credit counter: -1 on a read, +1 on credit_i, unchanged if both in the same cycle.
REQ-026 credit_i with credit_cnt_o=CREDITS and no read SHALL leave the count at CREDITS and set error_o; error_o clears only on reset.
REQ-027 Credit count 0 SHALL block all reads; a credit_i at 0 enables a read on the next cycle, not the same cycle.

Reset
REQ-028 With rst=0 at a clock edge: state IDLE, rr_ptr=0, lock_vc=0, credit_cnt_o=CREDITS, valid_o=0, flit_o=0, grant_o=0, error_o=0.
REQ-029 Reset asserted mid-packet SHALL abandon the lock with no further reads. read_o SHALL be 0 in every cycle with rst=0.

Verification
REQ-030 VC0 and VC2 each hold HEADTAIL, rr_ptr=0 -> read_o=0001, then 0100; valid_o high on the next two cycles; grant_o 0 then 2.
REQ-031 VC1 holds HEAD,BODY,TAIL and VC0 holds HEADTAIL arriving mid-packet -> read_o=0010 for 3 cycles, then 0001.
REQ-032 CREDITS=8, continuous eligible flits, no credit_i -> exactly 8 reads; count reaches 0; read_o=0; one credit_i pulse -> one read one cycle later.
REQ-033 read and credit_i in the same cycle with count=3 -> count stays 3; credit_i at count=8 with no read -> count 8, error_o=1 and stays 1.
REQ-034 Locked VC3 goes empty after BODY -> read_o=0, lock held; TAIL arrives -> read_o=1000, then IDLE with rr_ptr=0.
REQ-035 rst=0 while LOCKED on VC1 -> next cycle all outputs at reset values; rr_ptr=0 and VC0 is granted first.
